gpio_in_capture: RTL and testbench

GPIO_IN_CAPTURE -- requirements
Module: gpio_in_capture

---
 rtl/gpio_pkg.sv | 22 ++
 rtl/gpio_sync_edge.sv | 38 +++
 rtl/gpio_in_capture.sv | 89 ++++++++
 tb/tb_gpio_in_capture.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared GPIO register map: address constants used by both the input-capture
// block and the GPIO output block.
package gpio_pkg;

    localparam int ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_PIN  = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_RISE = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_FALL = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_IEN  = 2'd3;

    // Write-one-to-clear mask: returns data when this register is being written, else 0.
    function automatic logic [31:0] w1c_mask(
        input logic              we,
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] target,
        input logic [31:0]       data
    );
        return (we && (addr == target)) ? data : 32'd0;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop synchronizer plus previous-value register and edge detection,
// WIDTH bits in parallel. Everything resets to 0, so a pin held high through
// reset produces exactly one rising edge after release.
module gpio_sync_edge #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_async,
    output logic [WIDTH-1:0] pin_sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    // Synchronizer chain and one-cycle-old copy of the synchronized value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the old
            // value of the one before it, which is what builds a real shift chain.
            meta_q <= pin_async;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pin_sync = sync_q;
    assign rise     = sync_q & ~prev_q;
    assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/gpio_in_capture.sv
// GPIO input capture: synchronized pin readback, sticky W1C rise/fall status,
// interrupt enable mask and a registered level interrupt.
module gpio_in_capture
    import gpio_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out,
    output logic              rvalid,
    input  logic [WIDTH-1:0]  gpio_in,
    output logic              irq
);

    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] rise_det;
    logic [WIDTH-1:0] fall_det;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] ien_q;
    logic [WIDTH-1:0] rise_clr;
    logic [WIDTH-1:0] fall_clr;
    logic [WIDTH-1:0] rd_data;

    gpio_sync_edge #(
        .WIDTH (WIDTH)
    ) u_sync_edge (
        .clk       (clk),
        .reset     (reset),
        .pin_async (gpio_in),
        .pin_sync  (pin),
        .rise      (rise_det),
        .fall      (fall_det)
    );

    // Decode W1C clear masks for the status registers.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (defaults first), otherwise synthesis infers a latch.
        rise_clr = '0;
        fall_clr = '0;
        if (we && addr == ADDR_RISE) rise_clr = data_in;
        if (we && addr == ADDR_FALL) fall_clr = data_in;
    end

    // Read mux over the current (pre-write) register values.
    always_comb begin
        rd_data = pin;
        case (addr)
            ADDR_PIN:  rd_data = pin;
            ADDR_RISE: rd_data = rise_q;
            ADDR_FALL: rd_data = fall_q;
            ADDR_IEN:  rd_data = ien_q;
            default:   rd_data = pin;
        endcase
    end

    // Sticky status (a new edge beats a same-cycle clear) and interrupt enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_q <= '0;
            fall_q <= '0;
            ien_q  <= '0;
        end else begin
            rise_q <= (rise_q & ~rise_clr) | rise_det;
            fall_q <= (fall_q & ~fall_clr) | fall_det;
            if (we && addr == ADDR_IEN) ien_q <= data_in;
        end
    end

    // Registered read response and interrupt; data_out holds between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
            rvalid   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) data_out <= rd_data;
            irq <= |((rise_q | fall_q) & ien_q);
        end
    end

endmodule

// File: tb/tb_gpio_in_capture.sv
// Directed test of gpio_in_capture. Reads push their expected value into a
// scoreboard queue; a monitor pops and compares whenever rvalid is seen.
module tb_gpio_in_capture;
    import gpio_pkg::*;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              we = 1'b0;
    logic              re = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [WIDTH-1:0]  data_in = '0;
    logic [WIDTH-1:0]  gpio_in = '0;
    logic [WIDTH-1:0]  data_out;
    logic              rvalid;
    logic              irq;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_q[$];
    string            name_q[$];

    gpio_in_capture #(
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .re       (re),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .rvalid   (rvalid),
        .gpio_in  (gpio_in),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string nm);
        re   = 1'b1;
        addr = a;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        tick();
        re = 1'b0;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        we      = 1'b1;
        addr    = a;
        data_in = d;
        tick();
        we = 1'b0;
    endtask

    // Monitor: every rvalid must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 32'(rvalid), 32'd0);
            end else begin
                check(name_q.pop_front(), data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, gpio_in low.
        #2 reset = 1'b1;
        #1;
        check("reset_data_out", data_out, 32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        tick(3);
        reset = 1'b0;
        rd(ADDR_PIN, 32'h0000_0000, "pin_after_reset");
        check("irq_idle", 32'(irq), 32'd0);

        // Rising edges on a 0xA5A5A5A5 pattern; back-to-back reads.
        gpio_in = 32'hA5A5_A5A5;
        tick(4);
        rd(ADDR_RISE, 32'hA5A5_A5A5, "rise_a5");
        rd(ADDR_FALL, 32'h0000_0000, "fall_none");
        rd(ADDR_IEN,  32'h0000_0000, "ien_reset");
        rd(ADDR_PIN,  32'hA5A5_A5A5, "pin_a5");
        tick(2);
        check("data_out_hold", data_out, 32'hA5A5_A5A5);
        check("rvalid_one_cycle", 32'(rvalid), 32'd0);

        // W1C clear of RISE; writes to PIN are ignored.
        wr(ADDR_RISE, 32'hFFFF_FFFF);
        wr(ADDR_PIN,  32'h0000_0000);
        rd(ADDR_RISE, 32'h0000_0000, "rise_cleared");
        rd(ADDR_PIN,  32'hA5A5_A5A5, "pin_write_ignored");

        // Mixed transition: FALL = old & ~new, RISE = new & ~old.
        gpio_in = 32'h1234_5678;
        tick(4);
        rd(ADDR_FALL, 32'hA581_A185, "fall_mixed");  // 0xA5A5A5A5 & ~0x12345678
        rd(ADDR_RISE, 32'h1210_5258, "rise_mixed");  // 0x12345678 & ~0xA5A5A5A5

        // Interrupt on bit0 rising.
        wr(ADDR_RISE, 32'hFFFF_FFFF);
        wr(ADDR_FALL, 32'hFFFF_FFFF);
        wr(ADDR_IEN,  32'h0000_0001);
        rd(ADDR_IEN,  32'h0000_0001, "ien_written");
        check("irq_masked_clear", 32'(irq), 32'd0);
        gpio_in = 32'h1234_5679;
        tick(3);
        check("irq_not_before_4", 32'(irq), 32'd0);
        tick(1);
        check("irq_after_4", 32'(irq), 32'd1);
        wr(ADDR_RISE, 32'h0000_0001);
        tick(1);
        check("irq_cleared", 32'(irq), 32'd0);

        // Same-cycle edge detect and W1C of bit4: set wins.
        gpio_in = 32'h1234_5669;
        tick(4);
        wr(ADDR_RISE, 32'hFFFF_FFFF);
        wr(ADDR_FALL, 32'hFFFF_FFFF);
        gpio_in = 32'h1234_5679;
        tick(2);
        wr(ADDR_RISE, 32'h0000_0010);
        rd(ADDR_RISE, 32'h0000_0010, "set_wins_over_w1c");
        wr(ADDR_RISE, 32'h0000_0000);
        rd(ADDR_RISE, 32'h0000_0010, "w0_no_effect");

        // Simultaneous write and read of IEN returns the pre-write value.
        we      = 1'b1;
        re      = 1'b1;
        addr    = ADDR_IEN;
        data_in = 32'hFFFF_FFFF;
        exp_q.push_back(32'h0000_0001);
        name_q.push_back("rw_same_cycle");
        tick();
        we = 1'b0;
        re = 1'b0;
        rd(ADDR_IEN, 32'hFFFF_FFFF, "ien_all");
        check("irq_all_enabled", 32'(irq), 32'd1);

        // Reset while a read is pending: no rvalid, everything cleared at once.
        re   = 1'b1;
        addr = ADDR_RISE;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_kills_rvalid", 32'(rvalid), 32'd0);
        check("reset_kills_irq", 32'(irq), 32'd0);
        re = 1'b0;
        tick(2);
        check("reset_data_out_mid", data_out, 32'd0);
        reset = 1'b0;
        rd(ADDR_IEN,  32'h0000_0000, "ien_after_reset");
        rd(ADDR_FALL, 32'h0000_0000, "fall_after_reset");
        rd(ADDR_RISE, 32'h0000_0000, "rise_after_reset");
        tick(3);
        // Pins held high through reset report one rising edge after release.
        rd(ADDR_RISE, 32'h1234_5679, "rise_held_through_reset");
        rd(ADDR_FALL, 32'h0000_0000, "fall_held_through_reset");

        tick(3);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
